// File: rtl/dotprod_seq_pkg.sv
// rtl/dotprod_seq_pkg.sv - shared types and constants for the dotprod kernel sequencer
package dotprod_seq_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 16;
    localparam int TMO_W_DEF     = 24;
    // Kernel may still show the previous job's done flag for this many RUN cycles
    localparam int DONE_MASK_CYC = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        RESULT
    } state_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_LOAD,
        SEL_KERN
    } port_sel_t;

endpackage

// File: rtl/dotprod_sram_port_mux.sv
// rtl/dotprod_sram_port_mux.sv - one SRAM port: registered loader write, kernel pass-through or idle
module sram_port_mux
    import dotprod_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic              ld_wr_en_i,
    input  logic [DATA_W-1:0] kern_data_i,
    input  logic              kern_wr_en_i,
    input  logic              kern_rd_en_i,
    input  logic [ADDR_W-1:0] kern_addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o
);

    always_comb begin
        data_o  = '0;
        wr_en_o = 1'b0;
        rd_en_o = 1'b0;
        addr_o  = '0;
        case (sel_i)
            SEL_LOAD: begin
                data_o  = ld_data_i;
                wr_en_o = ld_wr_en_i;
                addr_o  = ld_addr_i;
            end
            SEL_KERN: begin
                data_o  = kern_data_i;
                wr_en_o = kern_wr_en_i;
                rd_en_o = kern_rd_en_i;
                addr_o  = kern_addr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dotprod_sequencer.sv
// rtl/dotprod_sequencer.sv - job sequencer: load SRAMs, start kernel, watchdog, return result
module dotprod_sequencer
    import dotprod_seq_pkg::*;
#(
    parameter int               DATA_W  = DATA_W_DEF,
    parameter int               ADDR_W  = ADDR_W_DEF,
    parameter int               TMO_W   = TMO_W_DEF,
    parameter logic [TMO_W-1:0] TIMEOUT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [31:0]       cfg_n,
    output logic              cmd_busy,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_a,
    input  logic [DATA_W-1:0] ld_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error,
    output logic              kern_start_sig,
    output logic [31:0]       kern_n,
    input  logic [DATA_W-1:0] kern_result,
    input  logic              kern_done_flag,
    input  logic [DATA_W-1:0] kern_a_out,
    input  logic              kern_a_wr_en,
    input  logic              kern_a_rd_en,
    input  logic [ADDR_W-1:0] kern_a_addr,
    input  logic [DATA_W-1:0] kern_b_out,
    input  logic              kern_b_wr_en,
    input  logic              kern_b_rd_en,
    input  logic [ADDR_W-1:0] kern_b_addr,
    output logic [DATA_W-1:0] a_out,
    output logic              a_wr_en,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] b_out,
    output logic              b_wr_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr
);

    localparam logic [32:0] N_MAX = 33'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_error_q, res_error_d;
    logic              ld_wr_q, ld_wr_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] ld_a_q, ld_a_d, ld_b_q, ld_b_d;
    port_sel_t         sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
            ld_wr_q     <= 1'b0;
            ld_addr_q   <= '0;
            ld_a_q      <= '0;
            ld_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
            ld_wr_q     <= ld_wr_d;
            ld_addr_q   <= ld_addr_d;
            ld_a_q      <= ld_a_d;
            ld_b_q      <= ld_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;
        ld_wr_d     = 1'b0;
        ld_addr_d   = ld_addr_q;
        ld_a_d      = ld_a_q;
        ld_b_d      = ld_b_q;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    n_d = cfg_n;
                    if ({1'b0, cfg_n} > N_MAX) begin
                        res_data_d  = '0;
                        res_error_d = 1'b1;
                        state_d     = RESULT;
                    end else if (cfg_n == 32'd0) begin
                        state_d = LAUNCH;
                    end else begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ld_wr_d   = 1'b1;
                    ld_addr_d = cnt_q[ADDR_W-1:0];
                    ld_a_d    = ld_a;
                    ld_b_d    = ld_b;
                    cnt_d     = cnt_q + 1'b1;
                    if (32'(cnt_q) == n_q - 32'd1) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // Done takes priority over a timeout landing on the same cycle
                if (wdog_q >= TMO_W'(DONE_MASK_CYC) && kern_done_flag) begin
                    res_data_d  = kern_result;
                    res_error_d = 1'b0;
                    state_d     = RESULT;
                end else if (TIMEOUT != '0 && wdog_q == TIMEOUT) begin
                    res_data_d  = '0;
                    res_error_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The final loader write lands in LAUNCH, so the pending write decides the port owner
    always_comb begin
        sel = SEL_IDLE;
        if (ld_wr_q) begin
            sel = SEL_LOAD;
        end else if (state_q == RUN) begin
            sel = SEL_KERN;
        end
    end

    assign cmd_busy       = (state_q != IDLE);
    assign ld_ready       = (state_q == LOAD);
    assign res_valid      = (state_q == RESULT);
    assign res_data       = res_data_q;
    assign res_error      = res_error_q;
    assign kern_start_sig = (state_q == LAUNCH);
    assign kern_n         = n_q;

    sram_port_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
        .sel_i        (sel),
        .ld_data_i    (ld_a_q),
        .ld_addr_i    (ld_addr_q),
        .ld_wr_en_i   (ld_wr_q),
        .kern_data_i  (kern_a_out),
        .kern_wr_en_i (kern_a_wr_en),
        .kern_rd_en_i (kern_a_rd_en),
        .kern_addr_i  (kern_a_addr),
        .data_o       (a_out),
        .wr_en_o      (a_wr_en),
        .rd_en_o      (a_rd_en),
        .addr_o       (a_addr)
    );

    sram_port_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
        .sel_i        (sel),
        .ld_data_i    (ld_b_q),
        .ld_addr_i    (ld_addr_q),
        .ld_wr_en_i   (ld_wr_q),
        .kern_data_i  (kern_b_out),
        .kern_wr_en_i (kern_b_wr_en),
        .kern_rd_en_i (kern_b_rd_en),
        .kern_addr_i  (kern_b_addr),
        .data_o       (b_out),
        .wr_en_o      (b_wr_en),
        .rd_en_o      (b_rd_en),
        .addr_o       (b_addr)
    );

endmodule

// File: tb/tb_dotprod_sequencer.sv
// tb/tb_dotprod_sequencer.sv - self-checking bench for dotprod_sequencer with SRAM and kernel models
`timescale 1ns/1ps
module tb_dotprod_sequencer;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk, rst, cmd_start, cmd_busy;
    logic [31:0]   cfg_n, kern_n;
    logic          ld_valid, ld_ready;
    logic [DW-1:0] ld_a, ld_b;
    logic          res_valid, res_ready, res_error;
    logic [DW-1:0] res_data, kern_result;
    logic          kern_start_sig, kern_done_flag;
    logic [DW-1:0] kern_a_out, kern_b_out, a_out, b_out;
    logic          kern_a_wr_en, kern_a_rd_en, kern_b_wr_en, kern_b_rd_en;
    logic [AW-1:0] kern_a_addr, kern_b_addr, a_addr, b_addr;
    logic          a_wr_en, a_rd_en, b_wr_en, b_rd_en;

    dotprod_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TMO_W(24), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cfg_n(cfg_n), .cmd_busy(cmd_busy),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
        .kern_start_sig(kern_start_sig), .kern_n(kern_n), .kern_result(kern_result),
        .kern_done_flag(kern_done_flag),
        .kern_a_out(kern_a_out), .kern_a_wr_en(kern_a_wr_en), .kern_a_rd_en(kern_a_rd_en),
        .kern_a_addr(kern_a_addr),
        .kern_b_out(kern_b_out), .kern_b_wr_en(kern_b_wr_en), .kern_b_rd_en(kern_b_rd_en),
        .kern_b_addr(kern_b_addr),
        .a_out(a_out), .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_addr(a_addr),
        .b_out(b_out), .b_wr_en(b_wr_en), .b_rd_en(b_rd_en), .b_addr(b_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } res_t;
    res_t sb[$];

    // SRAM models and activity logs
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    int wr_a_q[$];
    int wr_b_q[$];
    int wr_cyc[$];
    int cyc = 0;
    int start_cnt = 0;
    int en_cnt = 0;
    int kmode = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_wr_en === 1'b1) begin
            wr_a_q.push_back(int'(a_addr));
            wr_cyc.push_back(cyc);
            mem_a[a_addr[3:0]] <= a_out;
        end
        if (b_wr_en === 1'b1) begin
            wr_b_q.push_back(int'(b_addr));
            mem_b[b_addr[3:0]] <= b_out;
        end
    end

    always @(negedge clk) begin
        if (kern_start_sig === 1'b1) start_cnt++;
        if ((a_wr_en | a_rd_en | b_wr_en | b_rd_en) === 1'b1) en_cnt++;
    end

    // Kernel model: mode 0 reads both SRAMs and returns the dot product, 1 never finishes,
    // 2 raises done exactly on the watchdog's last cycle
    initial begin
        logic [31:0] acc;
        int kn;
        kern_done_flag = 1'b0; kern_result = '0;
        kern_a_out = '0; kern_a_wr_en = 1'b0; kern_a_rd_en = 1'b0; kern_a_addr = '0;
        kern_b_out = '0; kern_b_wr_en = 1'b0; kern_b_rd_en = 1'b0; kern_b_addr = '0;
        forever begin
            @(negedge clk);
            if (kern_start_sig === 1'b1) begin
                kern_done_flag = 1'b0;
                if (kmode == 0) begin
                    acc = '0;
                    kn = int'(kern_n);
                    for (int i = 0; i < kn && i < 16; i++) begin
                        @(negedge clk);
                        kern_a_rd_en = 1'b1; kern_a_addr = AW'(i);
                        kern_b_rd_en = 1'b1; kern_b_addr = AW'(i);
                        #1;
                        check("run_passthru_a", 64'({a_rd_en, a_wr_en, a_addr}), 64'({2'b10, AW'(i)}));
                        check("run_passthru_b", 64'({b_rd_en, b_wr_en, b_addr}), 64'({2'b10, AW'(i)}));
                        acc += mem_a[i] * mem_b[i];
                    end
                    @(negedge clk);
                    kern_a_rd_en = 1'b0; kern_b_rd_en = 1'b0;
                    kern_a_addr = '0; kern_b_addr = '0;
                    kern_result = acc;
                    kern_done_flag = 1'b1;
                end else if (kmode == 2) begin
                    repeat (17) @(negedge clk);
                    kern_result = 32'hABCD;
                    kern_done_flag = 1'b1;
                end
            end
        end
    end

    task automatic start_job(input int n);
        cmd_start = 1'b1;
        cfg_n = 32'(n);
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic load_elem(input logic [31:0] av, input logic [31:0] bv, input int bub);
        int w;
        repeat (bub) begin
            ld_valid = 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b1; ld_a = av; ld_b = bv;
        w = 0;
        while (ld_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ld_ready_seen", 64'(ld_ready), 64'(1));
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input bit start_on_accept, output int lat);
        res_t exp;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("res_valid_seen", 64'(res_valid), 64'(1));
        if (res_valid !== 1'b1) return;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty: got a result, expected none");
            return;
        end
        exp = sb[0];
        repeat (hold) begin
            check("hold_valid", 64'(res_valid), 64'(1));
            check("hold_data", 64'({res_data, res_error}), 64'(exp));
            @(negedge clk);
        end
        res_ready = 1'b1;
        if (start_on_accept) begin
            cmd_start = 1'b1;
            cfg_n = 32'd2;
        end
        check("res_data", 64'(res_data), 64'(exp.data));
        check("res_error", 64'(res_error), 64'(exp.err));
        void'(sb.pop_front());
        @(negedge clk);
        res_ready = 1'b0;
        cmd_start = 1'b0;
        check("idle_after_accept", 64'({res_valid, cmd_busy}), 64'(0));
    endtask

    typedef struct packed {
        int              n;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        int              bub;
        int              hold;
        logic [31:0]     exp_data;
        logic            exp_err;
        int              exp_writes;
        int              exp_starts;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        tbl[0] = '0; tbl[0].n = 4; tbl[0].a = {32'd4, 32'd3, 32'd2, 32'd1};
        tbl[0].b = {32'd8, 32'd7, 32'd6, 32'd5}; tbl[0].hold = 5; tbl[0].exp_data = 32'd70;
        tbl[0].exp_writes = 4; tbl[0].exp_starts = 1;
        tbl[1] = '0; tbl[1].n = 3; tbl[1].a = {32'd0, 32'd4, 32'd3, 32'd2};
        tbl[1].b = {32'd0, 32'd30, 32'd20, 32'd10}; tbl[1].bub = 2; tbl[1].exp_data = 32'd200;
        tbl[1].exp_writes = 3; tbl[1].exp_starts = 1;
        tbl[2] = '0; tbl[2].n = 0; tbl[2].exp_starts = 1;
        tbl[3] = '0; tbl[3].n = 65537; tbl[3].exp_err = 1'b1;
        tbl[4] = '0; tbl[4].n = 1; tbl[4].a = {96'd0, 32'hFFFF_FFFF}; tbl[4].b = {96'd0, 32'd2};
        tbl[4].hold = 1; tbl[4].exp_data = 32'hFFFF_FFFE; tbl[4].exp_writes = 1; tbl[4].exp_starts = 1;

        rst = 1'b1; cmd_start = 1'b0; cfg_n = '0; ld_valid = 1'b0; ld_a = '0; ld_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({cmd_busy, ld_ready, res_valid, res_error, kern_start_sig}), 64'(0));
        check("rst_sram_en", 64'({a_wr_en, a_rd_en, b_wr_en, b_rd_en}), 64'(0));
        check("rst_sram_addr", 64'({a_addr, b_addr}), 64'(0));
        check("rst_sram_data", 64'({a_out, b_out}), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_kern_n", 64'(kern_n), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            wr_a_q.delete(); wr_b_q.delete(); wr_cyc.delete();
            start_cnt = 0; en_cnt = 0; kmode = 0;
            sb.push_back({tbl[t].exp_data, tbl[t].exp_err});
            start_job(tbl[t].n);
            if (!tbl[t].exp_err) begin
                for (int e = 0; e < tbl[t].n; e++)
                    load_elem(tbl[t].a[e], tbl[t].b[e], (e == 0) ? 0 : tbl[t].bub);
            end
            collect(tbl[t].hold, 1'b0, lat);
            if (tbl[t].n == 0) check("n0_latency", 64'(lat), 64'(4));
            check("wr_count_a", 64'(wr_a_q.size()), 64'(tbl[t].exp_writes));
            check("wr_count_b", 64'(wr_b_q.size()), 64'(tbl[t].exp_writes));
            for (int k = 0; k < wr_a_q.size(); k++) check("wr_addr_a", 64'(wr_a_q[k]), 64'(k));
            for (int k = 0; k < wr_b_q.size(); k++) check("wr_addr_b", 64'(wr_b_q[k]), 64'(k));
            if (tbl[t].bub == 0 && tbl[t].exp_writes > 1)
                check("wr_consecutive", 64'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]), 64'(tbl[t].n - 1));
            check("start_pulses", 64'(start_cnt), 64'(tbl[t].exp_starts));
            if (tbl[t].exp_err) check("no_sram_enable", 64'(en_cnt), 64'(0));
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of LOAD, then a fresh job must start writing at address 0
        kmode = 0;
        start_job(4);
        load_elem(32'd1, 32'd1, 0);
        load_elem(32'd2, 32'd2, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 64'({cmd_busy, ld_ready, res_valid}), 64'(0));
        check("mid_rst_en", 64'({a_wr_en, a_rd_en, b_wr_en, b_rd_en}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        wr_a_q.delete(); wr_b_q.delete();
        sb.push_back({32'd143, 1'b0});
        start_job(2);
        load_elem(32'd7, 32'd9, 0);
        load_elem(32'd8, 32'd10, 0);
        collect(0, 1'b0, lat);
        check("post_rst_wr_count", 64'(wr_a_q.size()), 64'(2));
        for (int k = 0; k < wr_a_q.size(); k++) check("post_rst_wr_addr", 64'(wr_a_q[k]), 64'(k));
        repeat (2) @(negedge clk);

        // Maximum legal length is accepted; a start request while busy is ignored
        start_job(65536);
        check("nmax_loads", 64'({cmd_busy, ld_ready, res_valid}), 64'(3'b110));
        start_job(3);
        check("busy_start_ignored", 64'(kern_n), 64'(65536));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Watchdog expiry, then done coinciding with the last watchdog cycle
        kmode = 1;
        sb.push_back({32'd0, 1'b1});
        start_job(0);
        collect(0, 1'b0, lat);
        check("timeout_latency", 64'(lat), 64'(18));
        repeat (2) @(negedge clk);
        kmode = 2;
        sb.push_back({32'hABCD, 1'b0});
        start_job(0);
        collect(0, 1'b1, lat);
        check("done_at_timeout_latency", 64'(lat), 64'(18));
        repeat (2) @(negedge clk);
        check("accept_start_ignored", 64'({cmd_busy, kern_start_sig}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
